pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 27 ++
 rtl/pipe_adder_chunk.sv | 20 ++
 rtl/pipe_adder.sv | 126 ++++++++++++
 tb/tb_pipe_adder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the chunked pipelined adder.
//   DEF_WIDTH / DEF_CHUNK : default operand width and bits added per stage
//   stage_rec_t           : layout of one pipeline stage record at the
//                           default width (valid, carry, partial result,
//                           pending operand chunks, operand sign bits)
//   ovf_of()              : two's-complement overflow from the sign bits
package pipe_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef struct packed {
    logic                 vld;  // stage holds a live operand set
    logic                 cy;   // carry into the chunk this stage adds
    logic                 am;   // MSB of operand A
    logic                 bm;   // MSB of effective operand B (b or ~b)
    logic [DEF_WIDTH-1:0] acc;  // result chunks produced so far
    logic [DEF_WIDTH-1:0] pa;   // operand A chunks still to add, LSB aligned
    logic [DEF_WIDTH-1:0] pb;   // effective B chunks still to add, LSB aligned
  } stage_rec_t;

  // Overflow: operands share a sign and the result sign differs from it.
  function automatic logic ovf_of(input logic am, input logic bm, input logic sm);
    return (am == bm) && (sm != am);
  endfunction

endpackage

// File: rtl/pipe_adder_chunk.sv
// chunk_adder: CHUNK-bit combinational adder slice.
//   a, b : CHUNK-bit addends
//   ci   : carry in
//   s    : CHUNK-bit sum
//   co   : carry out
module chunk_adder
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract, CHUNK bits resolved per stage with a
// registered ripple carry between stages. Latency WIDTH/CHUNK cycles, one
// operand set per cycle, valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake for {a, b, cin, sub}
//   a, b                : WIDTH-bit operands
//   cin                 : carry-in (add) / borrow-in (sub)
//   sub                 : 0 add, 1 subtract
//   out_valid/out_ready : output handshake for {s, c, ovf}
//   s                   : sum / difference
//   c                   : carry-out (add) / not-borrow (sub)
//   ovf                 : signed overflow
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Same layout as pipe_adder_pkg::stage_rec_t, sized for this instance.
  typedef struct packed {
    logic             vld;
    logic             cy;
    logic             am;
    logic             bm;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
  } stage_t;

  // stg_p[k] holds the set about to add chunk k; stg_p[0] is the captured input.
  stage_t           stg_p [STAGES];
  logic [CHUNK-1:0] sum_c [STAGES];
  logic             co_c  [STAGES];
  logic [WIDTH-1:0] acc_nx[STAGES];

  // Result register (after the last chunk).
  logic             res_vld;
  logic             res_c;
  logic             res_am;
  logic             res_bm;
  logic [WIDTH-1:0] res_s;

  logic             adv;

  // The whole pipe advances unless a result is blocked at the output.
  assign adv      = !(res_vld && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Pending chunks are shifted down each stage, so chunk k is always at the LSBs.
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a  (stg_p[k].pa[CHUNK-1:0]),
      .b  (stg_p[k].pb[CHUNK-1:0]),
      .ci (stg_p[k].cy),
      .s  (sum_c[k]),
      .co (co_c[k])
    );
    // Chunk k of acc is still zero here, so OR merges the new result chunk.
    assign acc_nx[k] = stg_p[k].acc | (WIDTH'(sum_c[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_p[k] <= '0;
      end
      res_vld <= 1'b0;
      res_c   <= 1'b0;
      res_am  <= 1'b0;
      res_bm  <= 1'b0;
      res_s   <= '0;
    end else if (adv) begin
      // Capture: subtraction becomes a + ~b + !cin.
      stg_p[0].vld <= in_valid;
      stg_p[0].cy  <= cin ^ sub;
      stg_p[0].am  <= a[WIDTH-1];
      stg_p[0].bm  <= b[WIDTH-1] ^ sub;
      stg_p[0].acc <= '0;
      stg_p[0].pa  <= a;
      stg_p[0].pb  <= b ^ {WIDTH{sub}};
      // Chunk stages 0 .. STAGES-2 feed the next stage.
      for (int k = 1; k < STAGES; k++) begin
        stg_p[k].vld <= stg_p[k-1].vld;
        stg_p[k].cy  <= co_c[k-1];
        stg_p[k].am  <= stg_p[k-1].am;
        stg_p[k].bm  <= stg_p[k-1].bm;
        stg_p[k].acc <= acc_nx[k-1];
        stg_p[k].pa  <= stg_p[k-1].pa >> CHUNK;
        stg_p[k].pb  <= stg_p[k-1].pb >> CHUNK;
      end
      // Last chunk: its carry leaves as c and never wraps back.
      res_vld <= stg_p[STAGES-1].vld;
      res_c   <= co_c[STAGES-1];
      res_am  <= stg_p[STAGES-1].am;
      res_bm  <= stg_p[STAGES-1].bm;
      res_s   <= acc_nx[STAGES-1];
    end
  end

  assign out_valid = res_vld;
  assign s         = res_s;
  assign c         = res_c;
  assign ovf       = ovf_of(res_am, res_bm, res_s[WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int LAT   = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

  pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c         (c),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // Offer one operand set; expected result is hand-computed by the caller.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic ci, input logic sb_in,
                      input logic [WIDTH-1:0] se, input logic ce, input logic oe,
                      input bit lat);
    int   waits = 0;
    exp_t e;
    @(negedge clk);
    a        = av;
    b        = bv;
    cin      = ci;
    sub      = sb_in;
    in_valid = 1'b1;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
      in_valid = 1'b0;
    end else begin
      e.s   = se;
      e.c   = ce;
      e.ovf = oe;
      e.acc = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            fail_now("spurious_out_valid");
          end else if (out_ready) begin
            e = sb.pop_front();
            chk("s", 32'(s), 32'(e.s));
            chk("c", 32'(c), 32'(e.c));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("in_ready_drain", 32'(in_ready), 32'd1);
            if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(LAT));
          end else begin
            chk("stall_s", 32'(s), 32'(sb[0].s));
            chk("stall_c", 32'(c), 32'(sb[0].c));
            chk("stall_ovf", 32'(ovf), 32'(sb[0].ovf));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
          end
        end else begin
          chk("idle_in_ready", 32'(in_ready), 32'd1);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single directed sets with idle gaps
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle();
    drain();
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    idle();
    drain();

    // Back-to-back stream, add/sub and cin changing per set
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'h1000, 16'h0FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    idle();
    drain();

    // Stall with the pipe full
    out_ready = 1'b0;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain();
    chk("after_stall_count", 32'(sb.size()), 32'd0);

    // Reset with three sets in flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    send(16'h4444, 16'h1111, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b1);
    send(16'h0F0F, 16'h0101, 1'b1, 1'b0, 16'h1011, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_c", 32'(c), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #2;
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    end

    // Pipe still works after reset
    send(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
